ibex_mem_responder: RTL and testbench
=====================================

// Module: ibex_mem_responder
// PURPOSE
//  Memory-side responder for the Ibex core LSU/fetch bus (req/gnt/rvalid with 7-bit integrity).
//  Backs MemWords x 32b single-port storage, fixed-latency in-order responses, err on out-of-range.
//  Used as simulation/FPGA memory for the synthesis top; one instance per bus (instr or data).
// PARAMETERS
//  MemWords   1024          number of 32b words (power of two, >=16)
//  BaseAddr   32'h0010_0000 byte address of word 0 (MemWords*4 aligned)
//  Latency    1             grant-to-rvalid cycles, legal 1..4
//  InitValue  32'h0         value written to every word during init
// PORTS
//  clk_i         in   1   clock
//  rst_i         in   1   asynchronous reset, active-high
//  req_i         in   1   request valid
//  gnt_o         out  1   request accepted this cycle
//  we_i          in   1   1=write, 0=read
//  be_i          in   4   byte enables (writes only)
//  addr_i        in   32  byte address; bits [1:0] ignored
//  wdata_i       in   32  write data
//  wdata_intg_i  in   7   write data integrity (inverted SECDED 39/32)
//  rvalid_o      out  1   response valid
//  rdata_o       out  32  read data (0 for writes and errors)
//  rdata_intg_o  out  7   read data integrity
//  err_o         out  1   response error, qualified by rvalid_o
//  init_done_o   out  1   storage initialised, bus open
// BEHAVIOUR
//  - Reset: gnt_o=0, rvalid_o=0, rdata_o=0, rdata_intg_o=0, err_o=0, init_done_o=0; FSM->INIT, counter=0.
//  - FSM INIT: writes InitValue to word[cnt], cnt++ each cycle, gnt_o=0; at cnt==MemWords-1 -> READY next cycle.
//    READY: init_done_o=1, gnt_o = req_i (combinational, no back-pressure). No other transitions except reset.
//  - Decode: hit iff BaseAddr <= addr_i < BaseAddr+4*MemWords; index = (addr_i-BaseAddr)[log2(MemWords)+1:2].
//  - Granted write hit: bytes with be_i[k]=1 updated at the grant clock edge; be_i=0 is legal no-op, err_o=0.
//  - Granted read hit: full word sampled at grant edge (be_i ignored); a read granted the cycle after a write
//    to the same word returns the new data.
//  - Miss: no storage access; response err_o=1, rdata_o=0.
//  - Response: rvalid_o high exactly Latency cycles after the grant cycle (Latency=1 -> next cycle), one per
//    grant, strictly in order; back-to-back grants give back-to-back rvalid. rvalid_o, rdata_o, err_o registered.
//  - rdata_intg_o = inverted SECDED 39/32 encoding of rdata_o on every response (incl. zero data).
//  - Reset mid-operation: in-flight responses discarded, rvalid_o=0 from reset assertion; storage reinitialised.
// CONFIGURATION
//  IBEX_MEM_RESP_INTG_CHECK_EN defined: on granted write hit, wdata_intg_i is checked against encode(wdata_i);
//    mismatch -> write suppressed, response err_o=1. Reads unaffected.
//  Not defined: wdata_intg_i ignored, writes never error on integrity; rdata_intg_o still generated.
// STRUCTURE
//  - ibex_mem_resp_pkg: resp_state_e {RespInit, RespReady}; resp_t struct {valid, err, rdata};
//    LatencyMax=4 constant.
//  - Sub-module ibex_mem_resp_pipe: Latency-deep shift register of resp_t, async active-high clear.
//  - Integrity via prim_secded_inv_39_32_enc (rdata path, and wdata check when macro set).
// TESTING  (MemWords=1024, BaseAddr=0x0010_0000, Latency=2 unless stated)
//  1 Release reset, hold req_i=1 -> gnt_o=0 for 1024 cycles, init_done_o=1 on cycle 1024; read 0x0010_0010 -> 0x0.
//  2 Write 0x0010_0008=0xDEADBEEF be=0xF, then read -> rvalid 2 cycles after grant, rdata 0xDEADBEEF, err 0.
//  3 Then write be=0b0101 data 0x11223344 to 0x0010_0008, read -> 0xDE22BE44; rdata_intg_o matches encoder.
//  4 req_i high 3 cycles reading 0x..00/0x..04/0x..08 -> 3 grants, 3 consecutive rvalid in order; Latency=1 repeat.
//  5 Read 0x0010_1000 and 0x000F_FFFC -> err_o=1, rdata_o=0; write to 0x0010_1000 leaves memory unchanged.
//  6 Assert rst_i with 2 reads in flight -> rvalid_o=0 immediately, no stale rvalid after release;
//    with IBEX_MEM_RESP_INTG_CHECK_EN, write with wdata_intg_i bit0 flipped -> err_o=1, word unchanged.

Source files
------------

// File: rtl/ibex_mem_resp_pkg.sv
// Shared types for the Ibex memory responder: FSM states, response record, latency bound.
package ibex_mem_resp_pkg;

    typedef enum logic {
        RespInit,
        RespReady
    } resp_state_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    localparam int unsigned LatencyMax = 4;

endpackage

// File: rtl/ibex_mem_responder_if.sv
// Ibex req/gnt/rvalid memory bus with 7-bit data integrity on both directions.
interface ibex_mem_responder_if;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [6:0]  wdata_intg_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [6:0]  rdata_intg_o;
    logic        err_o;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i, wdata_intg_i,
        input  gnt_o, rvalid_o, rdata_o, rdata_intg_o, err_o
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i, wdata_intg_i,
        output gnt_o, rvalid_o, rdata_o, rdata_intg_o, err_o
    );
endinterface

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-depth response delay line; depth equals the grant-to-rvalid latency.
module ibex_mem_resp_pipe
    import ibex_mem_resp_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  resp_t push,
    output resp_t pop
);
    resp_t stage_q [Depth];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= push;
            for (int unsigned i = 1; i < Depth; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign pop = stage_q[Depth-1];
endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted SECDED(39,32) encoder: data passes through, check bits are parities XOR 7'h2A.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);
    logic [6:0] parity;

    assign parity[0] = ^(data_i & 32'h2606_BD25);
    assign parity[1] = ^(data_i & 32'hDEBA_8050);
    assign parity[2] = ^(data_i & 32'h413D_89AA);
    assign parity[3] = ^(data_i & 32'h3123_4ED1);
    assign parity[4] = ^(data_i & 32'hC2C1_323B);
    assign parity[5] = ^(data_i & 32'h2DCC_624C);
    assign parity[6] = ^(data_i & 32'h9850_5586);

    // Inversion keeps all-zero words from having all-zero check bits.
    assign data_o = {parity ^ 7'h2A, data_i};
endmodule

// File: rtl/ibex_mem_responder.sv
// Single-port memory responder for the Ibex bus, in-order fixed-latency responses.
// Define IBEX_MEM_RESP_INTG_CHECK_EN to reject writes whose wdata integrity is wrong.
module ibex_mem_responder
    import ibex_mem_resp_pkg::*;
#(
    parameter int unsigned MemWords  = 1024,
    parameter logic [31:0] BaseAddr  = 32'h0010_0000,
    parameter int unsigned Latency   = 1,
    parameter logic [31:0] InitValue = 32'h0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ibex_mem_responder_if.slave  bus,
    output logic                 init_done_o
);
    localparam int unsigned IdxW = $clog2(MemWords);

    resp_state_e     state_q;
    logic [IdxW-1:0] cnt_q;
    logic [31:0]     mem [MemWords];

    logic [31:0]     offset;
    logic [IdxW-1:0] idx;
    logic            hit;
    logic            wintg_ok;
    logic            wr_en;
    logic            unused_intg;
    logic            unused_bits;
    resp_t           push;
    resp_t           pop;
    logic [38:0]     rdata_enc;

    assign offset = bus.addr_i - BaseAddr;
    assign idx    = offset[IdxW+1:2];
    // 33-bit compare so a window ending at 4 GiB cannot wrap.
    assign hit    = ({1'b0, bus.addr_i} >= {1'b0, BaseAddr}) &&
                    ({1'b0, bus.addr_i} < ({1'b0, BaseAddr} + (33'(MemWords) << 2)));

`ifdef IBEX_MEM_RESP_INTG_CHECK_EN
    logic [38:0] wdata_enc;

    prim_secded_inv_39_32_enc u_wdata_enc (
        .data_i (bus.wdata_i),
        .data_o (wdata_enc)
    );

    assign wintg_ok    = (wdata_enc[38:32] == bus.wdata_intg_i);
    assign unused_intg = ^wdata_enc[31:0];
`else
    assign wintg_ok    = 1'b1;
    assign unused_intg = ^bus.wdata_intg_i;
`endif

    assign bus.gnt_o = bus.req_i & init_done_o;
    assign wr_en     = bus.gnt_o & bus.we_i & hit & wintg_ok;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RespInit;
            cnt_q       <= '0;
            init_done_o <= 1'b0;
        end else begin
            unique case (state_q)
                RespInit: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IdxW'(MemWords - 1)) begin
                        state_q     <= RespReady;
                        init_done_o <= 1'b1;
                    end
                end
                RespReady: begin
                    init_done_o <= 1'b1;
                end
                default: begin
                    state_q     <= RespInit;
                    init_done_o <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; the init sweep clears it after every reset.
    always_ff @(posedge clk_i) begin
        if (state_q == RespInit) begin
            mem[cnt_q] <= InitValue;
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_i[k]) begin
                    mem[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        push       = '0;
        push.valid = bus.gnt_o;
        push.err   = bus.gnt_o & (~hit | (bus.we_i & ~wintg_ok));
        if (bus.gnt_o && hit && !bus.we_i) begin
            push.rdata = mem[idx];
        end
    end

    ibex_mem_resp_pipe #(
        .Depth (Latency)
    ) u_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop)
    );

    prim_secded_inv_39_32_enc u_rdata_enc (
        .data_i (pop.rdata),
        .data_o (rdata_enc)
    );

    assign bus.rvalid_o     = pop.valid;
    assign bus.rdata_o      = pop.rdata;
    assign bus.err_o        = pop.err;
    assign bus.rdata_intg_o = pop.valid ? rdata_enc[38:32] : 7'h0;

    assign unused_bits = ^{rdata_enc[31:0], offset[31:IdxW+2], offset[1:0]};
endmodule

// File: tb/tb_ibex_mem_responder.sv
// Randomised self-checking bench: two responders (Latency 2 and 1) against a memory model.
module tb_ibex_mem_responder;
    localparam int unsigned MemWords = 1024;
    localparam logic [31:0] BaseAddr = 32'h0010_0000;
`ifdef IBEX_MEM_RESP_INTG_CHECK_EN
    localparam bit IntgChk = 1'b1;
`else
    localparam bit IntgChk = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_l2;
    logic done_l1;
    int   checks = 0;
    int   failures = 0;

    ibex_mem_responder_if bus_l2 ();
    ibex_mem_responder_if bus_l1 ();

    ibex_mem_responder #(
        .MemWords (MemWords), .BaseAddr (BaseAddr), .Latency (2), .InitValue (32'h0)
    ) dut_l2 (
        .clk_i (clk), .rst_i (rst), .bus (bus_l2), .init_done_o (done_l2)
    );

    ibex_mem_responder #(
        .MemWords (MemWords), .BaseAddr (BaseAddr), .Latency (1), .InitValue (32'h0)
    ) dut_l1 (
        .clk_i (clk), .rst_i (rst), .bus (bus_l1), .init_done_o (done_l1)
    );

    always #5 clk = ~clk;

    // Reference memory and per-run op / expectation / observation tables
    logic [31:0] mdl [2][MemWords];
    logic        op_we    [64];
    logic [31:0] op_addr  [64];
    logic [3:0]  op_be    [64];
    logic [31:0] op_wdata [64];
    logic        op_bad   [64];
    logic [31:0] exp_rdata [64];
    logic        exp_err   [64];
    int          obs_gcyc  [64];
    int          obs_lat   [64];
    logic [31:0] obs_rdata [64];
    logic        obs_err   [64];
    logic [6:0]  obs_intg  [64];
    int          obs_cnt;
    int          obs_extra;

    function automatic logic [6:0] enc7(input logic [31:0] d);
        logic [6:0] p;
        p[0] = ^(d & 32'h2606_BD25);
        p[1] = ^(d & 32'hDEBA_8050);
        p[2] = ^(d & 32'h413D_89AA);
        p[3] = ^(d & 32'h3123_4ED1);
        p[4] = ^(d & 32'hC2C1_323B);
        p[5] = ^(d & 32'h2DCC_624C);
        p[6] = ^(d & 32'h9850_5586);
        return p ^ 7'h2A;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < MemWords; w++) mdl[s][w] = 32'h0;
        end
    endtask

    // Record op i and apply it to the model in issue order.
    task automatic set_op(input int s, input int i, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata, input logic bad);
        int unsigned w;
        logic        in_range;
        op_we[i] = we; op_addr[i] = addr; op_be[i] = be; op_wdata[i] = wdata; op_bad[i] = bad;
        in_range = (addr >= BaseAddr) && (addr < BaseAddr + 4 * MemWords);
        exp_rdata[i] = 32'h0;
        exp_err[i]   = !in_range;
        if (in_range) begin
            w = (addr - BaseAddr) / 4;
            if (!we) begin
                exp_rdata[i] = mdl[s][w];
            end else if (IntgChk && bad) begin
                exp_err[i] = 1'b1;
            end else begin
                for (int k = 0; k < 4; k++) if (be[k]) mdl[s][w][8*k +: 8] = wdata[8*k +: 8];
            end
        end
    endtask

    task automatic drive(input int s, input logic req, input int i);
        logic [6:0] ig;
        ig = enc7(op_wdata[i]) ^ {6'b0, op_bad[i]};
        if (s == 0) begin
            bus_l2.req_i = req; bus_l2.we_i = op_we[i]; bus_l2.be_i = op_be[i];
            bus_l2.addr_i = op_addr[i]; bus_l2.wdata_i = op_wdata[i]; bus_l2.wdata_intg_i = ig;
        end else begin
            bus_l1.req_i = req; bus_l1.we_i = op_we[i]; bus_l1.be_i = op_be[i];
            bus_l1.addr_i = op_addr[i]; bus_l1.wdata_i = op_wdata[i]; bus_l1.wdata_intg_i = ig;
        end
    endtask

    function automatic logic get_gnt(input int s);
        return (s == 0) ? bus_l2.gnt_o : bus_l1.gnt_o;
    endfunction

    function automatic logic get_rvalid(input int s);
        return (s == 0) ? bus_l2.rvalid_o : bus_l1.rvalid_o;
    endfunction

    // Issues ops 0..n-1 back to back and collects responses; called and returns at a negedge.
    task automatic bus_run(input int s, input int n);
        int issued;
        int cyc;
        issued = 0; cyc = 0; obs_cnt = 0; obs_extra = 0;
        while ((issued < n || obs_cnt < n) && cyc < 200) begin
            drive(s, issued < n, (issued < n) ? issued : 0);
            #1;
            if (issued < n && get_gnt(s)) begin
                obs_gcyc[issued] = cyc;
                issued++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (get_rvalid(s)) begin
                if (obs_cnt < issued) begin
                    obs_lat[obs_cnt]   = cyc - obs_gcyc[obs_cnt];
                    obs_rdata[obs_cnt] = (s == 0) ? bus_l2.rdata_o : bus_l1.rdata_o;
                    obs_err[obs_cnt]   = (s == 0) ? bus_l2.err_o : bus_l1.err_o;
                    obs_intg[obs_cnt]  = (s == 0) ? bus_l2.rdata_intg_o : bus_l1.rdata_intg_o;
                    obs_cnt++;
                end else begin
                    obs_extra++;
                end
            end
        end
        drive(s, 1'b0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) begin
            op_we[i] = 0; op_addr[i] = 0; op_be[i] = 0; op_wdata[i] = 0; op_bad[i] = 0;
        end
        drive(0, 1'b1, 0);
        drive(1, 1'b1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_l2.gnt_o, bus_l2.rvalid_o, bus_l2.err_o, done_l2} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctl gnt/rvalid/err/done got %b exp 0000",
                     {bus_l2.gnt_o, bus_l2.rvalid_o, bus_l2.err_o, done_l2});
        end
        checks++;
        if ({bus_l2.rdata_o, bus_l2.rdata_intg_o} !== 39'h0) begin
            failures++;
            $display("FAIL reset_data rdata %h intg %h exp 0", bus_l2.rdata_o,
                     bus_l2.rdata_intg_o);
        end
        checks++;
        if ({bus_l1.gnt_o, bus_l1.rvalid_o, done_l1} !== 3'b0) begin
            failures++;
            $display("FAIL reset_l1 gnt/rvalid/done got %b exp 000",
                     {bus_l1.gnt_o, bus_l1.rvalid_o, done_l1});
        end
    endtask

    task automatic test_init();
        int done_cyc;
        int gnt_bad;
        done_cyc = -1; gnt_bad = 0;
        rst = 1'b0;
        for (int k = 1; k <= 1100 && done_cyc < 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_l2) done_cyc = k;
            else if (bus_l2.gnt_o || bus_l1.gnt_o) gnt_bad++;
        end
        checks++;
        if (done_cyc !== 1024) begin
            failures++; $display("FAIL init_cycles got %0d exp 1024", done_cyc);
        end
        checks++;
        if (gnt_bad !== 0) begin
            failures++; $display("FAIL init_gnt grants during init got %0d exp 0", gnt_bad);
        end
        checks++;
        if ({bus_l2.gnt_o, done_l1} !== 2'b11) begin
            failures++; $display("FAIL ready_gnt gnt/done_l1 got %b exp 11",
                                 {bus_l2.gnt_o, done_l1});
        end
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        model_reset();
        set_op(0, 0, 1'b0, 32'h0010_0010, 4'hF, 32'h0, 1'b0);
        bus_run(0, 1);
        checks++;
        if (obs_cnt !== 1 || {obs_rdata[0], obs_err[0]} !== {exp_rdata[0], exp_err[0]}) begin
            failures++;
            $display("FAIL init_read cnt %0d rdata %h err %b exp rdata %h err %b", obs_cnt,
                     obs_rdata[0], obs_err[0], exp_rdata[0], exp_err[0]);
        end
    endtask

    task automatic test_write_read();
        set_op(0, 0, 1'b1, 32'h0010_0008, 4'hF, 32'hDEAD_BEEF, 1'b0);
        set_op(0, 1, 1'b0, 32'h0010_0008, 4'h0, 32'h0, 1'b0);
        set_op(0, 2, 1'b1, 32'h0010_0008, 4'b0101, 32'h1122_3344, 1'b0);
        set_op(0, 3, 1'b0, 32'h0010_000A, 4'h0, 32'h0, 1'b0);
        set_op(0, 4, 1'b1, 32'h0010_0008, 4'h0, 32'hFFFF_FFFF, 1'b0);
        set_op(0, 5, 1'b0, 32'h0010_0008, 4'h1, 32'h0, 1'b0);
        bus_run(0, 6);
        checks++;
        if (obs_cnt !== 6 || obs_extra !== 0) begin
            failures++; $display("FAIL wr_rd count got %0d extra %0d exp 6", obs_cnt, obs_extra);
        end
        for (int i = 0; i < obs_cnt; i++) begin
            checks++;
            if ({4'(obs_lat[i]), obs_err[i], obs_rdata[i], obs_intg[i]} !==
                {4'd2, exp_err[i], exp_rdata[i], enc7(exp_rdata[i])}) begin
                failures++;
                $display("FAIL wr_rd[%0d] lat %0d err %b rdata %h intg %h exp 2 %b %h %h", i,
                         obs_lat[i], obs_err[i], obs_rdata[i], obs_intg[i], exp_err[i],
                         exp_rdata[i], enc7(exp_rdata[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            set_op(s, 0, 1'b1, 32'h0010_0000, 4'hF, $urandom, 1'b0);
            set_op(s, 1, 1'b1, 32'h0010_0004, 4'hF, $urandom, 1'b0);
            set_op(s, 2, 1'b0, 32'h0010_0000, 4'hF, 32'h0, 1'b0);
            set_op(s, 3, 1'b0, 32'h0010_0004, 4'hF, 32'h0, 1'b0);
            set_op(s, 4, 1'b0, 32'h0010_0008, 4'hF, 32'h0, 1'b0);
            bus_run(s, 5);
            checks++;
            if (obs_cnt !== 5 || obs_extra !== 0) begin
                failures++;
                $display("FAIL b2b[%0d] count got %0d extra %0d exp 5", s, obs_cnt, obs_extra);
            end
            for (int i = 0; i < obs_cnt; i++) begin
                checks++;
                if ({obs_gcyc[i], 4'(obs_lat[i]), obs_err[i], obs_rdata[i], obs_intg[i]} !==
                    {i, 4'(lat_of(s)), exp_err[i], exp_rdata[i], enc7(exp_rdata[i])}) begin
                    failures++;
                    $display("FAIL b2b[%0d][%0d] gcyc %0d lat %0d err %b rdata %h intg %h exp %0d %0d %b %h %h",
                             s, i, obs_gcyc[i], obs_lat[i], obs_err[i], obs_rdata[i],
                             obs_intg[i], i, lat_of(s), exp_err[i], exp_rdata[i],
                             enc7(exp_rdata[i]));
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        set_op(0, 0, 1'b1, 32'h0010_0000, 4'hF, 32'hA5A5_0001, 1'b0);
        set_op(0, 1, 1'b1, 32'h0010_0FFC, 4'hF, 32'h5A5A_0002, 1'b0);
        set_op(0, 2, 1'b0, 32'h0010_1000, 4'hF, 32'h0, 1'b0);
        set_op(0, 3, 1'b0, 32'h000F_FFFC, 4'hF, 32'h0, 1'b0);
        set_op(0, 4, 1'b1, 32'h0010_1000, 4'hF, 32'hCAFE_F00D, 1'b0);
        set_op(0, 5, 1'b1, 32'h000F_FFFC, 4'hF, 32'hCAFE_F00D, 1'b0);
        set_op(0, 6, 1'b0, 32'h0010_0000, 4'hF, 32'h0, 1'b0);
        set_op(0, 7, 1'b0, 32'h0010_0FFF, 4'hF, 32'h0, 1'b0);
        bus_run(0, 8);
        checks++;
        if (obs_cnt !== 8 || obs_extra !== 0) begin
            failures++; $display("FAIL oor count got %0d extra %0d exp 8", obs_cnt, obs_extra);
        end
        for (int i = 0; i < obs_cnt; i++) begin
            checks++;
            if ({4'(obs_lat[i]), obs_err[i], obs_rdata[i], obs_intg[i]} !==
                {4'd2, exp_err[i], exp_rdata[i], enc7(exp_rdata[i])}) begin
                failures++;
                $display("FAIL oor[%0d] lat %0d err %b rdata %h intg %h exp 2 %b %h %h", i,
                         obs_lat[i], obs_err[i], obs_rdata[i], obs_intg[i], exp_err[i],
                         exp_rdata[i], enc7(exp_rdata[i]));
            end
        end
    endtask

    task automatic test_intg();
        for (int s = 0; s < 2; s++) begin
            set_op(s, 0, 1'b1, 32'h0010_000C, 4'hF, 32'h1357_9BDF, 1'b0);
            set_op(s, 1, 1'b1, 32'h0010_000C, 4'hF, 32'h2468_ACE0, 1'b1);
            set_op(s, 2, 1'b0, 32'h0010_000C, 4'hF, 32'h0, 1'b1);
            bus_run(s, 3);
            checks++;
            if (obs_cnt !== 3 || obs_extra !== 0) begin
                failures++;
                $display("FAIL intg[%0d] count got %0d extra %0d exp 3", s, obs_cnt, obs_extra);
            end
            for (int i = 0; i < obs_cnt; i++) begin
                checks++;
                if ({obs_err[i], obs_rdata[i], obs_intg[i]} !==
                    {exp_err[i], exp_rdata[i], enc7(exp_rdata[i])}) begin
                    failures++;
                    $display("FAIL intg[%0d][%0d] err %b rdata %h intg %h exp %b %h %h", s, i,
                             obs_err[i], obs_rdata[i], obs_intg[i], exp_err[i], exp_rdata[i],
                             enc7(exp_rdata[i]));
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        int stale;
        int seen_done;
        stale = 0; seen_done = 0;
        set_op(0, 0, 1'b0, 32'h0010_0008, 4'hF, 32'h0, 1'b0);
        set_op(0, 1, 1'b0, 32'h0010_000C, 4'hF, 32'h0, 1'b0);
        drive(0, 1'b1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({bus_l2.rvalid_o, bus_l1.rvalid_o, done_l2, done_l1} !== 4'b0) begin
            failures++;
            $display("FAIL rst_inflight rvalid_l2/l1 done_l2/l1 got %b exp 0000",
                     {bus_l2.rvalid_o, bus_l1.rvalid_o, done_l2, done_l1});
        end
        drive(0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 1100 && seen_done == 0; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus_l2.rvalid_o || bus_l1.rvalid_o) stale++;
            if (done_l2 && done_l1) seen_done = 1;
        end
        checks++;
        if (stale !== 0 || seen_done !== 1) begin
            failures++; $display("FAIL rst_stale stale rvalid %0d done %0d exp 0 1", stale,
                                 seen_done);
        end
        model_reset();
        for (int s = 0; s < 2; s++) begin
            set_op(s, 0, 1'b0, 32'h0010_0008, 4'hF, 32'h0, 1'b0);
            bus_run(s, 1);
            checks++;
            if (obs_cnt !== 1 || {obs_rdata[0], obs_err[0]} !== {exp_rdata[0], exp_err[0]}) begin
                failures++;
                $display("FAIL rst_reinit[%0d] cnt %0d rdata %h err %b exp %h %b", s, obs_cnt,
                         obs_rdata[0], obs_err[0], exp_rdata[0], exp_err[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          r;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 40; i++) begin
                r = $urandom_range(0, 99);
                if (r < 80) a = BaseAddr + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
                else if (r < 88) a = BaseAddr + 32'h1000 + $urandom_range(0, 255);
                else if (r < 94) a = BaseAddr - 32'd1 - $urandom_range(0, 255);
                else a = $urandom;
                set_op(s, i, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
                       ($urandom_range(0, 7) == 0));
            end
            bus_run(s, 40);
            checks++;
            if (obs_cnt !== 40 || obs_extra !== 0) begin
                failures++;
                $display("FAIL rand[%0d] count got %0d extra %0d exp 40", s, obs_cnt, obs_extra);
            end
            for (int i = 0; i < obs_cnt; i++) begin
                checks++;
                if ({4'(obs_lat[i]), obs_err[i], obs_rdata[i], obs_intg[i]} !==
                    {4'(lat_of(s)), exp_err[i], exp_rdata[i], enc7(exp_rdata[i])}) begin
                    failures++;
                    $display("FAIL rand[%0d][%0d] addr %h we %b lat %0d err %b rdata %h intg %h exp %0d %b %h %h",
                             s, i, op_addr[i], op_we[i], obs_lat[i], obs_err[i], obs_rdata[i],
                             obs_intg[i], lat_of(s), exp_err[i], exp_rdata[i],
                             enc7(exp_rdata[i]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_intg();
        test_random();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
